// File: rtl/double_dabble_pkg.sv
// Shared types and elaboration helpers for the iterative binary-to-BCD converter.
package double_dabble_pkg;

   typedef enum logic [1:0] {DD_IDLE, DD_CONVERT, DD_DONE} dd_state_t;

   // Smallest digit count d with 10**d > 2**bits - 1.
   function automatic int unsigned dd_min_digits(int bits);
      longint unsigned max_val;
      longint unsigned pow10;
      int unsigned     digits;
      max_val = (64'(1) << bits) - 64'(1);
      pow10   = 64'(10);
      digits  = 1;
      for (int i = 0; i < 20; i++) begin
         if (pow10 <= max_val) begin
            pow10  = pow10 * 64'(10);
            digits = digits + 1;
         end
      end
      return digits;
   endfunction

endpackage

// File: rtl/double_dabble_cell.sv
// One BCD digit cell: add 3 when the digit is 5 or more, ahead of the shift.
module double_dabble_cell (
   input  logic [3:0] digit,
   output logic [3:0] digit_adj_c
);

   assign digit_adj_c = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/double_dabble_sequencer.sv
// Iterative binary-to-BCD converter: one add-3/shift step per enabled clock on a
// single row of digit cells, with valid/ready handshakes on both sides.
module double_dabble_sequencer
   import double_dabble_pkg::*;
#(
   parameter int unsigned Input_Bit_Width = 8,
   parameter int unsigned Digit_Count     = 3
) (
   input  logic                                   clk,
   input  logic                                   clk_en,
   input  logic                                   sync_rst,
   input  logic [Input_Bit_Width-1:0]             bin_data,
   input  logic                                   bin_valid,
   output logic                                   bin_ready,
   output logic [Digit_Count*4-1:0]               bcd_data,
   output logic [$clog2(Digit_Count+1)-1:0]       bcd_sig_digits,
   output logic                                   bcd_valid,
   input  logic                                   bcd_ready
);

   localparam int unsigned BcdW  = Digit_Count * 4;
   localparam int unsigned WorkW = BcdW + Input_Bit_Width;
   localparam int unsigned CntW  = $clog2(Input_Bit_Width + 1);
   localparam int unsigned SigW  = $clog2(Digit_Count + 1);

   if (Input_Bit_Width < 1 || Input_Bit_Width > 32) begin : g_width_check
      $fatal(1, "double_dabble_sequencer: Input_Bit_Width must be 1..32");
   end
   if (Digit_Count < dd_min_digits(Input_Bit_Width)) begin : g_digit_check
      $fatal(1, "double_dabble_sequencer: Digit_Count too small for Input_Bit_Width");
   end

   dd_state_t                  state_q;
   logic [BcdW-1:0]            bcd_q;
   logic [Input_Bit_Width-1:0] bin_q;
   logic [CntW-1:0]            cnt_q;
   logic                       live_q;
   logic [BcdW-1:0]            bcd_adj_c;
   logic [WorkW-1:0]           work_shift_c;
   logic [SigW-1:0]            sig_c;

   for (genvar d = 0; d < Digit_Count; d++) begin : g_cell
      double_dabble_cell u_cell (
         .digit       (bcd_q[d*4 +: 4]),
         .digit_adj_c (bcd_adj_c[d*4 +: 4])
      );
   end

   assign work_shift_c = {bcd_adj_c, bin_q} << 1;

   // Index of the most significant non-zero digit plus one; a zero result reports 1.
   always_comb begin
      sig_c = SigW'(1);
      for (int d = 0; d < int'(Digit_Count); d++) begin
         if (bcd_q[d*4 +: 4] != 4'd0) sig_c = SigW'(d + 1);
      end
   end

   // live_q keeps bin_ready low while reset is held without a path from sync_rst.
   always_comb begin
      bin_ready = 1'b0;
      case (state_q)
         DD_IDLE: bin_ready = live_q;
         DD_DONE: bin_ready = bcd_ready;
         default: bin_ready = 1'b0;
      endcase
   end

   assign bcd_valid      = (state_q == DD_DONE);
   assign bcd_data       = bcd_q;
   assign bcd_sig_digits = sig_c;

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state_q <= DD_IDLE;
         bcd_q   <= '0;
         bin_q   <= '0;
         cnt_q   <= '0;
         live_q  <= 1'b0;
      end else begin
         live_q <= 1'b1;
         if (clk_en) begin
            case (state_q)
               DD_IDLE: begin
                  if (bin_valid && bin_ready) begin
                     bcd_q   <= '0;
                     bin_q   <= bin_data;
                     cnt_q   <= '0;
                     state_q <= DD_CONVERT;
                  end
               end
               DD_CONVERT: begin
                  bcd_q <= work_shift_c[WorkW-1 -: BcdW];
                  bin_q <= work_shift_c[Input_Bit_Width-1:0];
                  cnt_q <= cnt_q + CntW'(1);
                  if (cnt_q == CntW'(Input_Bit_Width - 1)) state_q <= DD_DONE;
               end
               DD_DONE: begin
                  if (bcd_ready) begin
                     if (bin_valid) begin
                        bcd_q   <= '0;
                        bin_q   <= bin_data;
                        cnt_q   <= '0;
                        state_q <= DD_CONVERT;
                     end else begin
                        state_q <= DD_IDLE;
                     end
                  end
               end
               default: state_q <= DD_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_double_dabble_sequencer.sv
// Directed bench for double_dabble_sequencer: 8-bit/3-digit and 16-bit/5-digit instances.
module tb_double_dabble_sequencer;

   logic        clk = 1'b0;
   logic        clk_en = 1'b1;
   logic        sync_rst = 1'b1;
   logic [7:0]  bin_data = '0;
   logic        bin_valid = 1'b0;
   logic        bin_ready;
   logic [11:0] bcd_data;
   logic [1:0]  bcd_sig_digits;
   logic        bcd_valid;
   logic        bcd_ready = 1'b0;

   logic        sync_rst16 = 1'b1;
   logic [15:0] bin_data16 = '0;
   logic        bin_valid16 = 1'b0;
   logic        bin_ready16;
   logic [19:0] bcd_data16;
   logic [2:0]  bcd_sig_digits16;
   logic        bcd_valid16;
   logic        bcd_ready16 = 1'b0;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   double_dabble_sequencer #(.Input_Bit_Width(8), .Digit_Count(3)) dut (
      .clk            (clk),
      .clk_en         (clk_en),
      .sync_rst       (sync_rst),
      .bin_data       (bin_data),
      .bin_valid      (bin_valid),
      .bin_ready      (bin_ready),
      .bcd_data       (bcd_data),
      .bcd_sig_digits (bcd_sig_digits),
      .bcd_valid      (bcd_valid),
      .bcd_ready      (bcd_ready)
   );

   double_dabble_sequencer #(.Input_Bit_Width(16), .Digit_Count(5)) dut16 (
      .clk            (clk),
      .clk_en         (1'b1),
      .sync_rst       (sync_rst16),
      .bin_data       (bin_data16),
      .bin_valid      (bin_valid16),
      .bin_ready      (bin_ready16),
      .bcd_data       (bcd_data16),
      .bcd_sig_digits (bcd_sig_digits16),
      .bcd_valid      (bcd_valid16),
      .bcd_ready      (bcd_ready16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Counts edges until bcd_valid rises, bounded.
   task automatic wait_valid(output int edges);
      edges = 0;
      while (!bcd_valid && edges < 40) begin
         tick();
         edges++;
      end
   endtask

   // Single conversion from IDLE; lat counts the cycle after the transfer edge as 1.
   task automatic run_conv(input string tag, input logic [7:0] v,
                           input logic [11:0] exp_bcd, input logic [1:0] exp_sig);
      int lat;
      bcd_ready = 1'b0;
      bin_data  = v;
      bin_valid = 1'b1;
      chk({tag, "_ready"}, 32'(bin_ready), 32'd1);
      tick();
      bin_valid = 1'b0;
      bin_data  = 8'hA5;
      lat = 1;
      while (!bcd_valid && lat < 40) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'd9);
      chk({tag, "_data"}, 32'(bcd_data), 32'(exp_bcd));
      chk({tag, "_sig"}, 32'(bcd_sig_digits), 32'(exp_sig));
      bcd_ready = 1'b1;
      tick();
      bcd_ready = 1'b0;
      chk({tag, "_idle"}, 32'({bcd_valid, bin_ready}), 32'b01);
   endtask

   initial begin
      int  e;
      int  en_edges;
      int  cyc;
      logic stable_bad;
      logic saw_valid;
      logic [11:0] prev;

      // Reset
      repeat (3) tick();
      chk("rst_ready", 32'(bin_ready), 32'd0);
      chk("rst_valid", 32'(bcd_valid), 32'd0);
      chk("rst_data", 32'(bcd_data), 32'h000);
      chk("rst_sig", 32'(bcd_sig_digits), 32'd1);
      sync_rst   = 1'b0;
      sync_rst16 = 1'b0;
      tick();
      chk("rel_ready", 32'(bin_ready), 32'd1);

      // Single conversions
      run_conv("c255", 8'd255, 12'h255, 2'd3);
      run_conv("c0", 8'd0, 12'h000, 2'd1);
      run_conv("c7", 8'd7, 12'h007, 2'd1);
      run_conv("c10", 8'd10, 12'h010, 2'd2);

      // Back-to-back with both sides always willing
      bcd_ready = 1'b1;
      bin_valid = 1'b1;
      bin_data  = 8'd123;
      tick();
      bin_data = 8'd45;
      wait_valid(e);
      chk("b2b_lat0", 32'(e), 32'd8);
      chk("b2b_d123", 32'(bcd_data), 32'h123);
      chk("b2b_rdy", 32'(bin_ready), 32'd1);
      tick();
      bin_data = 8'd200;
      wait_valid(e);
      chk("b2b_gap1", 32'(e + 1), 32'd9);
      chk("b2b_d045", 32'(bcd_data), 32'h045);
      tick();
      bin_valid = 1'b0;
      wait_valid(e);
      chk("b2b_gap2", 32'(e + 1), 32'd9);
      chk("b2b_d200", 32'(bcd_data), 32'h200);
      tick();
      chk("b2b_idle", 32'({bcd_valid, bin_ready}), 32'b01);

      // Backpressure holds the result and blocks a pending operand
      bcd_ready = 1'b0;
      bin_data  = 8'd99;
      bin_valid = 1'b1;
      tick();
      bin_valid = 1'b0;
      wait_valid(e);
      chk("bp_d099", 32'(bcd_data), 32'h099);
      bin_data  = 8'd77;
      bin_valid = 1'b1;
      repeat (20) begin
         tick();
         chk("bp_hold", 32'({bcd_valid, bin_ready, bcd_data}), 32'({1'b1, 1'b0, 12'h099}));
      end
      bcd_ready = 1'b1;
      #1;
      chk("bp_rdy_comb", 32'(bin_ready), 32'd1);
      tick();
      bcd_ready = 1'b0;
      bin_valid = 1'b0;
      chk("bp_loaded", 32'(bcd_valid), 32'd0);
      wait_valid(e);
      chk("bp_lat", 32'(e), 32'd8);
      chk("bp_d077", 32'(bcd_data), 32'h077);
      bcd_ready = 1'b1;
      tick();
      bcd_ready = 1'b0;

      // clk_en toggled every other cycle
      bin_data  = 8'd128;
      bin_valid = 1'b1;
      tick();
      bin_valid  = 1'b0;
      en_edges   = 1;
      cyc        = 0;
      stable_bad = 1'b0;
      clk_en     = 1'b1;
      while (!bcd_valid && cyc < 60) begin
         clk_en = ~clk_en;
         prev   = bcd_data;
         tick();
         cyc++;
         if (clk_en) en_edges++;
         else if (bcd_data !== prev) stable_bad = 1'b1;
      end
      clk_en = 1'b1;
      chk("en_lat", 32'(en_edges), 32'd9);
      chk("en_hold", 32'(stable_bad), 32'd0);
      chk("en_d128", 32'(bcd_data), 32'h128);
      bcd_ready = 1'b1;
      tick();
      bcd_ready = 1'b0;

      // Reset partway through a conversion discards it
      bin_data  = 8'd200;
      bin_valid = 1'b1;
      tick();
      bin_valid = 1'b0;
      repeat (4) tick();
      sync_rst = 1'b1;
      tick();
      chk("mid_rst_valid", 32'(bcd_valid), 32'd0);
      chk("mid_rst_ready", 32'(bin_ready), 32'd0);
      sync_rst = 1'b0;
      tick();
      chk("mid_rel_ready", 32'(bin_ready), 32'd1);
      saw_valid = 1'b0;
      repeat (12) begin
         tick();
         if (bcd_valid) saw_valid = 1'b1;
      end
      chk("mid_no_result", 32'(saw_valid), 32'd0);

      // 16-bit operand into five digits
      chk("w16_ready", 32'(bin_ready16), 32'd1);
      bin_data16  = 16'd65535;
      bin_valid16 = 1'b1;
      tick();
      bin_valid16 = 1'b0;
      e = 0;
      while (!bcd_valid16 && e < 40) begin
         tick();
         e++;
      end
      chk("w16_lat", 32'(e), 32'd16);
      chk("w16_data", 32'(bcd_data16), 32'h65535);
      chk("w16_sig", 32'(bcd_sig_digits16), 32'd5);
      bcd_ready16 = 1'b1;
      tick();
      bcd_ready16 = 1'b0;
      chk("w16_idle", 32'(bcd_valid16), 32'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/double_dabble_sequencer.md
# double_dabble_sequencer

Iterative binary-to-BCD converter controller. It accepts one binary word over a valid/ready handshake and runs one add-3/shift step per enabled clock on a single row of digit cells, taking Input_Bit_Width steps. It then presents the packed BCD result and its significant-digit count over a second valid/ready handshake. This is the low-area alternative to the fully unrolled pipelined converter, for status/display paths where throughput is not critical.

## Interface
- Input_Bit_Width, 8: width of the binary operand; legal range 1..32.
- Digit_Count, 3: number of BCD output digits.
  - Elaboration fatal unless 10**Digit_Count > 2**Input_Bit_Width - 1.
- clk  input  1  single clock; all logic on its rising edge.
- clk_en  input  1  global enable; when low, all state holds and no transfer occurs.
- sync_rst  input  1  synchronous, active-high reset; overrides clk_en.
- bin_data  input  Input_Bit_Width  binary operand.
- bin_valid  input  1  operand valid.
- bin_ready  output  1  converter can accept an operand.
- bcd_data  output  Digit_Count*4  packed BCD; digit 0 is bits [3:0] (least significant).
- bcd_sig_digits  output  $clog2(Digit_Count+1)  index of the most significant non-zero digit plus 1; value 1 when the result is zero.
- bcd_valid  output  1  result valid.
- bcd_ready  input  1  consumer accepts the result.

## Operation
- Working register: W = {bcd[Digit_Count*4-1:0], bin[Input_Bit_Width-1:0]}, plus step counter cnt of width $clog2(Input_Bit_Width+1).
- The FSM has three states.
- IDLE:
  - bin_ready=1.
  - Input transfer: bin_valid & bin_ready & clk_en.
  - On transfer: bcd field := 0, bin field := bin_data, cnt := 0, go to CONVERT.
- CONVERT:
  - bin_ready=0, bcd_valid=0.
  - Each enabled cycle: every digit d with d>=5 becomes d+3 (4-bit, no carry out), then W := W<<1 with 0 shifted in, and cnt++.
  - When the step with cnt==Input_Bit_Width-1 completes, go to DONE.
- DONE:
  - bcd_valid=1, bcd_data = bcd field, held stable until the output transfer.
  - Output transfer: bcd_valid & bcd_ready & clk_en.
  - bin_ready = bcd_ready. This is the combinational path from bcd_ready to bin_ready, and it is the only one.
  - Output transfer together with an input transfer: load the new operand, go to CONVERT.
  - Output transfer alone: go to IDLE.
- bcd_sig_digits is combinational from the bcd field. It is meaningful only while bcd_valid=1.
- Digit adjust never overflows, given the elaboration check.
- bin_valid while not ready: ignored. The bench must not see the operand consumed.
- bin_data is sampled only on the transfer edge; later changes have no effect.
- Reset mid-operation: the current conversion is discarded and no result is produced.

## Timing
- Reset values:
  - state=IDLE, W=0, cnt=0.
  - bcd_valid=0, bcd_data=0, bcd_sig_digits=1.
  - bin_ready=0 while sync_rst is high, 1 on the first cycle after release.
- Latency:
  - Input transfer at edge T.
  - CONVERT steps occur at edges T+1..T+N (N = Input_Bit_Width, all cycles enabled).
  - bcd_valid is high in the cycle after edge T+N.
- Throughput with bcd_ready and bin_valid held high: one result per N+1 cycles.
- Cycles with clk_en=0 stretch latency one-for-one. Outputs stay constant during them.

## Structure
- Shared package double_dabble_pkg holds:
  - typedef enum logic [1:0] {DD_IDLE, DD_CONVERT, DD_DONE} dd_state_t;
  - function dd_min_digits(int bits), used for the elaboration check.
- Sub-module: double_dabble_cell (4-bit conditional add-3), instantiated Digit_Count times in a generate loop on the bcd field.
- Shift, counter, FSM and the leading-zero count stay in this module.

## Test plan
- N=8, bin_data=8'd255, bcd_ready=1 -> bcd_data=12'h255, bcd_sig_digits=2'd3, bcd_valid first high exactly 9 cycles after the transfer edge.
- bin_data=0 -> bcd_data=12'h000, bcd_sig_digits=1. Then bin_data=8'd7 -> 12'h007, sig=1. Then 8'd10 -> 12'h010, sig=2.
- Back-to-back: bin_valid and bcd_ready held high with operands 123, 45, 200 -> results 12'h123, 12'h045, 12'h200 on bcd_valid pulses spaced 9 cycles apart. Each result's handshake cycle also accepts the next operand.
- Backpressure: bcd_ready low for 20 cycles after result 99 -> bcd_data=12'h099 and bcd_valid stay stable, bin_ready=0, and an offered operand is not consumed until bcd_ready rises.
- clk_en toggled every other cycle during conversion of 8'd128 -> result 12'h128, with latency of 9 enabled cycles.
- sync_rst asserted at step 4 of a conversion -> next cycle state=IDLE, bcd_valid=0, bin_ready=1. With Input_Bit_Width=16, Digit_Count=5, 16'd65535 -> 20'h65535, sig=5.
